spi_tx_arbiter: RTL
===================

# spi_tx_arbiter

Round-robin arbiter that shares the single SPI output path among four word-stream requesters. It forwards the granted requester's 16-bit words onto the `DATA`/`ENA` write port of the output SPI process. Arbitration is packet-atomic: a grant is held until the requester's last word or a stall timeout. It sits between the per-source command generators and the output SPI FIFO, and applies backpressure through `DOWN_READY`.

## Interface
Parameters:
- `TIMEOUT`, default 255: stall cycles tolerated mid-packet before forced release. Legal range 1..255.

Ports (reset is synchronous and active-high):
- `CLK`  in  1  single clock for all logic.
- `RST`  in  1  synchronous, active-high reset.
- `REQ`  in  4  requester i has a valid word on its lane.
- `REQ_DATA`  in  64  lane i occupies bits [16i+15:16i].
- `REQ_LAST`  in  4  requester i's current word ends its packet.
- `ACK`  out  4  combinational, at most one bit set; word of requester i accepted this cycle.
- `DOWN_READY`  in  1  downstream FIFO can take a word this cycle.
- `DATA`  out  16  registered word to the SPI output FIFO.
- `ENA`  out  1  registered write strobe, one per accepted word.
- `GRANT`  out  4  registered one-hot current owner; 0 when none.
- `TIMEOUT_ERR`  out  1  one-cycle pulse on forced release.
- `state_mon`  out  2  current FSM state.

## Operation
- Reset values: `DATA`=0, `ENA`=0, `GRANT`=0, `TIMEOUT_ERR`=0, `ACK`=0, `state_mon`=0, state IDLE, round-robin pointer `ptr`=3 (so requester 0 has priority first), stall counter 0.
- States: IDLE=0, XFER=1, RELEASE=2. Encoding 3 is unused; if reached, go to IDLE.
- IDLE:
  - If any `REQ` bit is set, select the first set bit scanning from `ptr+1` upward, modulo 4.
  - Register `GRANT` one-hot, clear the stall counter, go to XFER.
  - No `ACK` is issued in IDLE.
- XFER (owner g):
  - `ACK[g] = REQ[g] & DOWN_READY`. `ACK` is 0 for every non-owner; their `REQ` is ignored.
  - On ACK: next edge `DATA`<=lane g, `ENA`<=1, and the stall counter clears. Otherwise `ENA`<=0 and `DATA` holds.
  - On ACK with `REQ_LAST[g]`=1: go to RELEASE.
  - Stall counter increments only in cycles where `REQ[g]`=0. Cycles with `DOWN_READY`=0 and `REQ[g]`=1 do not count (downstream stall is legal and unbounded).
  - When the counter reaches `TIMEOUT` with no ACK: pulse `TIMEOUT_ERR` next edge, go to RELEASE.
  - If ACK with LAST and the timeout condition occur in the same cycle, ACK wins: word forwarded, no error.
- RELEASE:
  - `GRANT`<=0, `ptr`<=g, go to IDLE. Lasts one cycle.
- Counter is 8 bits and saturates; it never wraps.
- `RST` asserted mid-packet: the packet is abandoned, all outputs go to reset values at the next edge, and no `TIMEOUT_ERR` is raised. The partial packet already written downstream is not recalled.

## Timing
- `REQ` sampled high at edge n in IDLE → `GRANT` valid after edge n+1. The first `ACK` can occur in the cycle following edge n+1.
- ACK in cycle k → `ENA`=1 and `DATA` valid after edge k+1. Latency is 1 cycle; throughput is 1 word per cycle.
- Last-word ACK in cycle k → RELEASE in cycle k+1, IDLE in cycle k+2, earliest next ACK in cycle k+3.
- Timeout: the owner drops `REQ` starting in cycle s → `TIMEOUT_ERR` high for exactly one cycle, `TIMEOUT` cycles later, at the edge that enters RELEASE.
- Requesters must hold `REQ_DATA`/`REQ_LAST` stable while `REQ`=1 and no `ACK` has been given.

## Test plan
- Single packet: requester 2 sends 3 words 0xA001, 0xA002, 0xA003 (LAST on the third), `DOWN_READY`=1 → `GRANT`=4'b0100, three consecutive `ACK[2]`, `ENA` high 3 cycles with those values, then `GRANT`=0.
- Fairness: all four `REQ` permanently high, 1-word packets, starting from reset → grant order 0,1,2,3,0; each ACK is 3 cycles after the previous one.
- Backpressure: `DOWN_READY` low for 10 cycles mid-packet with `TIMEOUT`=4 → no `ACK`, `ENA`=0, no `TIMEOUT_ERR`, and the packet resumes intact.
- Timeout: `TIMEOUT`=4, owner 1 drops `REQ` after word 1 → `TIMEOUT_ERR` one-cycle pulse 4 cycles later, `GRANT` released, requester 2 granted next.
- Simultaneous: ACK with LAST lands in the counter-expiry cycle → word forwarded, `TIMEOUT_ERR` stays 0.
- Reset mid-packet: `RST` high for 1 cycle during word 2 of 4 → all outputs 0, `ptr`=3, and requester 0 wins the next arbitration.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// spi_tx_arbiter
//
// Shares the single SPI output write port among four word-stream requesters.
// Arbitration is round-robin and packet-atomic. Once a requester is granted,
// it keeps the port until one of two things happens:
//   - its word flagged LAST is accepted, or
//   - it stops presenting words for TIMEOUT cycles. This is a forced release,
//     and TIMEOUT_ERR is pulsed.
// Downstream backpressure (DOWN_READY low) may stall a packet indefinitely
// and never counts toward the timeout.
//
// Parameters:
//   TIMEOUT      stall cycles tolerated mid-packet before forced release (1..255)
//
// Ports:
//   CLK          single clock
//   RST          synchronous, active-high reset
//   REQ          per-requester "valid word on lane" flags
//   REQ_DATA     four 16-bit lanes, lane i at [16i+15:16i]
//   REQ_LAST     per-requester "current word ends the packet" flags
//   ACK          combinational, one-hot or zero: owner's word accepted this cycle
//   DOWN_READY   downstream FIFO can take a word this cycle
//   DATA         registered word to the SPI output FIFO
//   ENA          registered write strobe, one per accepted word
//   GRANT        registered one-hot current owner (0 when none)
//   TIMEOUT_ERR  one-cycle pulse on forced release
//   state_mon    current FSM state (IDLE=0, XFER=1, RELEASE=2)
// ---------------------------------------------------------------------------
module spi_tx_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  REQ,
    input  logic [63:0] REQ_DATA,
    input  logic [3:0]  REQ_LAST,
    output logic [3:0]  ACK,
    input  logic        DOWN_READY,
    output logic [15:0] DATA,
    output logic        ENA,
    output logic [3:0]  GRANT,
    output logic        TIMEOUT_ERR,
    output logic [1:0]  state_mon
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
    localparam logic [7:0] STALL_MAX   = 8'hFF;

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;      // last requester served
    logic [1:0]  owner_q, owner_d;  // index of the current grant holder
    logic [3:0]  grant_q, grant_d;
    logic [7:0]  stall_q, stall_d;  // cycles the owner has had REQ low
    logic [15:0] data_q, data_d;
    logic        ena_q, ena_d;
    logic        err_q, err_d;

    // Owner's lane, selected by index.
    logic        owner_req;
    logic        owner_last;
    logic [15:0] owner_word;

    assign owner_req  = REQ[owner_q];
    assign owner_last = REQ_LAST[owner_q];
    assign owner_word = REQ_DATA[{owner_q, 4'b0000} +: 16];

    // Round-robin pick: first set REQ bit scanning upward from ptr+1.
    // k = 4 wraps back to ptr itself, so the last server is considered last.
    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] cand;

    // NOTE: every signal driven in a combinational block gets a default at the
    // top; any path that left one unassigned would infer a latch.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!pick_valid && REQ[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        stall_d = stall_q;
        data_d  = data_q;   // DATA holds when no word is accepted
        ena_d   = 1'b0;
        err_d   = 1'b0;
        ACK     = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                // No ACK in IDLE; a new owner is registered first.
                if (pick_valid) begin
                    owner_d = pick_idx;
                    grant_d = 4'b0001 << pick_idx;
                    stall_d = 8'd0;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                if (owner_req && DOWN_READY) begin
                    // An accepted word takes priority over an expiring counter.
                    // A LAST word accepted on the expiry cycle is forwarded
                    // without an error.
                    ACK[owner_q] = 1'b1;
                    data_d       = owner_word;
                    ena_d        = 1'b1;
                    stall_d      = 8'd0;
                    if (owner_last) begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    // Only an absent owner word counts as a stall.
                    // Downstream backpressure with REQ high is unbounded.
                    if (!owner_req && (stall_q != STALL_MAX)) begin
                        stall_d = stall_q + 8'd1;
                    end
                    if (stall_q >= TIMEOUT_LIM) begin
                        err_d   = 1'b1;
                        state_d = ST_RELEASE;
                    end
                end
            end

            ST_RELEASE: begin
                grant_d = 4'b0000;
                ptr_d   = owner_q;
                state_d = ST_IDLE;
            end

            default: begin
                // Unused encoding: recover to IDLE with no owner.
                grant_d = 4'b0000;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its inputs regardless of order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // Reset abandons any packet in flight and raises no error.
            state_q <= ST_IDLE;
            ptr_q   <= 2'd3;     // requester 0 has first priority
            owner_q <= 2'd0;
            grant_q <= 4'b0000;
            stall_q <= 8'd0;
            data_q  <= 16'h0000;
            ena_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            stall_q <= stall_d;
            data_q  <= data_d;
            ena_q   <= ena_d;
            err_q   <= err_d;
        end
    end

    assign DATA        = data_q;
    assign ENA         = ena_q;
    assign GRANT       = grant_q;
    assign TIMEOUT_ERR = err_q;
    assign state_mon   = state_q;

endmodule
